// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, addresses instruction memory,
// and registers the fetched word into the IF/ID pipeline register.
// Honours hazard-unit freeze and taken-branch redirect/flush from decode,
// and stops fetching once the PC passes the end of the loaded program.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter int WORD_LEN   = 32,
    parameter int PROG_BYTES = 44
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       brTaken,
    input  logic signed [WORD_LEN-1:0] brOffset,
    input  logic        [WORD_LEN-1:0] instruction,
    output logic        [WORD_LEN-1:0] instAddr,
    output logic        [WORD_LEN-1:0] ifIdPc,
    output logic        [WORD_LEN-1:0] ifIdInstr,
    output logic                       ifIdValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                fetchCount,
    output logic [31:0]                stallCount
`endif
);

    typedef enum logic {RUN, DONE} state_t;

    localparam logic [WORD_LEN-1:0] PROG_END = WORD_LEN'(PROG_BYTES);
    localparam logic [WORD_LEN-1:0] STEP     = WORD_LEN'(4);

    state_t              state;
    logic [WORD_LEN-1:0] pc_p0;
    logic [WORD_LEN-1:0] pc_seq;
    logic [WORD_LEN-1:0] br_target;

    // Branch target relative to the instruction sitting in ID; wraps modulo
    // 2^WORD_LEN and is forced word-aligned.
    function automatic logic [WORD_LEN-1:0] branch_target(
        input logic        [WORD_LEN-1:0] base_pc,
        input logic signed [WORD_LEN-1:0] word_off
    );
        logic [WORD_LEN-1:0] off_u;
        logic [WORD_LEN-1:0] sum;
        off_u = word_off;
        sum   = base_pc + STEP + (off_u << 2);
        sum[1:0] = 2'b00;
        return sum;
    endfunction

    assign instAddr  = pc_p0;
    assign pc_seq    = pc_p0 + STEP;
    assign br_target = branch_target(ifIdPc, brOffset);

    // Fetch FSM: PC, state and IF/ID register with rst > branch > freeze > state action.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc_p0     <= '0;
            ifIdPc    <= '0;
            ifIdInstr <= '0;
            ifIdValid <= 1'b0;
        end else if (brTaken) begin
            state     <= RUN;
            pc_p0     <= br_target;
            ifIdPc    <= '0;
            ifIdInstr <= '0;
            ifIdValid <= 1'b0;
        end else if (freeze) begin
            state     <= state;
        end else begin
            case (state)
                RUN: begin
                    ifIdPc    <= pc_p0;
                    ifIdInstr <= instruction;
                    ifIdValid <= 1'b1;
                    pc_p0     <= pc_seq;
                    if (pc_seq >= PROG_END) begin
                        state <= DONE;
                    end
                end
                default: begin
                    ifIdPc    <= '0;
                    ifIdInstr <= '0;
                    ifIdValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    // Counts real fetches into IF/ID and freeze cycles spent while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (!brTaken && !freeze && state == RUN) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (!brTaken && freeze && state == RUN) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// freeze/branch/reset traffic, compared against a behavioural fetch model.
module tb_if_stage;

    localparam int W = 32;
    localparam int PB = 44;

    logic                clk = 1'b0;
    logic                rst;
    logic                freeze;
    logic                brTaken;
    logic signed [W-1:0] brOffset;
    logic        [W-1:0] instruction;
    logic        [W-1:0] instAddr;
    logic        [W-1:0] ifIdPc;
    logic        [W-1:0] ifIdInstr;
    logic                ifIdValid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mem [64];

    // behavioural model state
    logic [W-1:0] m_pc;
    logic [W-1:0] m_ifpc;
    logic [W-1:0] m_ifinstr;
    logic         m_ifvalid;
    bit           m_done;
    logic [31:0]  m_fetch;
    logic [31:0]  m_stall;

    if_stage #(.WORD_LEN(W), .PROG_BYTES(PB)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .brTaken     (brTaken),
        .brOffset    (brOffset),
        .instruction (instruction),
        .instAddr    (instAddr),
        .ifIdPc      (ifIdPc),
        .ifIdInstr   (ifIdInstr),
        .ifIdValid   (ifIdValid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetchCount  (fetchCount),
        .stallCount  (stallCount)
`endif
    );

    always #5 clk = ~clk;

    // instruction memory: combinational, high address bits ignored
    always_comb instruction = mem[instAddr[7:2]];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instAddr"}, instAddr, m_pc);
        check({tag, ".ifIdPc"}, ifIdPc, m_ifpc);
        check({tag, ".ifIdInstr"}, ifIdInstr, m_ifinstr);
        check({tag, ".ifIdValid"}, {31'd0, ifIdValid}, {31'd0, m_ifvalid});
`ifdef IF_PERF_CNT_EN
        check({tag, ".fetchCount"}, fetchCount, m_fetch);
        check({tag, ".stallCount"}, stallCount, m_stall);
`endif
    endtask

    // Apply one cycle of inputs, advance the model by the stage's rules, check after the edge.
    task automatic step(input string tag, input logic r, input logic f, input logic b,
                        input int off);
        longint tgt;
        rst = r; freeze = f; brTaken = b; brOffset = off;
        if (r) begin
            m_pc = 0; m_done = 0; m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
            m_fetch = 0; m_stall = 0;
        end else if (b) begin
            tgt = longint'(m_ifpc) + 4 + longint'(off) * 4;
            m_pc = tgt[31:0];
            m_done = 0; m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
        end else if (f) begin
            if (!m_done) m_stall++;
        end else if (!m_done) begin
            m_ifpc = m_pc; m_ifinstr = mem[m_pc[7:2]]; m_ifvalid = 1;
            m_fetch++;
            m_pc = m_pc + 4;
            if (m_pc >= PB) m_done = 1;
        end else begin
            m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // run free until the model's IF/ID holds the given PC (bounded)
    task automatic run_until_ifpc(input logic [W-1:0] target);
        int k = 0;
        while (!(m_ifvalid && m_ifpc == target) && k < 40) begin
            step("run", 0, 0, 0, 0);
            k++;
        end
        n_tests++;
        if (k >= 40) begin
            n_fail++;
            $error("FAIL run_until_ifpc: observed timeout expected ifIdPc %0h", target);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst = 1; freeze = 0; brTaken = 0; brOffset = 0;

        // reset held while freeze and branch are also asserted
        step("rst0", 1, 1, 1, 5);
        step("rst1", 1, 1, 1, -3);
        check("rst.pc", instAddr, 32'd0);
        check("rst.valid", {31'd0, ifIdValid}, 32'd0);

        // three free-running fetches
        step("free0", 0, 0, 0, 0);
        check("free0.ifIdInstr", ifIdInstr, mem[0]);
        step("free1", 0, 0, 0, 0);
        step("free2", 0, 0, 0, 0);
        check("free2.instAddr", instAddr, 32'd12);
        check("free2.ifIdInstr", ifIdInstr, mem[2]);

        // two-cycle freeze at PC=12
        step("frz0", 0, 1, 0, 0);
        step("frz1", 0, 1, 0, 0);
        check("frz.pc", instAddr, 32'd12);
        check("frz.ifIdPc", ifIdPc, 32'd8);
        step("frzrel", 0, 0, 0, 0);
        check("frzrel.ifIdInstr", ifIdInstr, mem[3]);

        // branch from ifIdPc=32 with offset -3
        run_until_ifpc(32);
        step("br32", 0, 0, 1, -3);
        check("br32.pc", instAddr, 32'd24);
        step("br32next", 0, 0, 0, 0);
        check("br32next.ifIdPc", ifIdPc, 32'd24);
        check("br32next.ifIdInstr", ifIdInstr, mem[6]);

        // run to program end
        run_until_ifpc(40);
        check("done.pc", instAddr, 32'd44);
        step("done0", 0, 0, 0, 0);
        check("done0.valid", {31'd0, ifIdValid}, 32'd0);
        check("done0.pc", instAddr, 32'd44);
        step("done1", 0, 0, 0, 0);

        // resume from DONE via branch with ifIdPc=40 (re-run to 40 first)
        step("rstB", 1, 0, 0, 0);
        run_until_ifpc(40);
        step("resume", 0, 0, 1, -8);
        check("resume.pc", instAddr, 32'd12);

        // freeze and branch together with ifIdPc=40
        run_until_ifpc(40);
        step("frzbr", 0, 1, 1, -8);
        check("frzbr.pc", instAddr, 32'd12);
        check("frzbr.valid", {31'd0, ifIdValid}, 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            logic r, f, b;
            int off;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 10);
            off = int'($urandom_range(0, 15)) - 8;
            step("rand", r, f, b, off);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline: holds the program counter, drives the byte address into the instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It honours the hazard unit's freeze and the decode stage's taken-branch redirect (with flush), and it stops fetching once the PC runs past the loaded program.

## Interface
- `WORD_LEN`, 32, datapath/PC width.
- `PROG_BYTES`, 44, byte size of the loaded program; fetch stops when PC ≥ this.

- `clk`  in  1  single pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard-unit stall; hold PC and IF/ID.
- `brTaken`  in  1  branch in ID resolved taken this cycle.
- `brOffset`  in  WORD_LEN  signed word offset from the branch immediate, sign-extended.
- `instruction`  in  WORD_LEN  combinational read data from instruction memory.
- `instAddr`  out  WORD_LEN  byte address to instruction memory, equal to PC.
- `ifIdPc`  out  WORD_LEN  PC of the instruction in IF/ID.
- `ifIdInstr`  out  WORD_LEN  instruction in IF/ID; 0 = NOP.
- `ifIdValid`  out  1  IF/ID holds a real fetched instruction.
- `fetchCount`, `stallCount`  out  32 each  present only with `IF_PERF_CNT_EN`.

## Operation
- FSM states: RUN, DONE.
- Reset:
  - PC = 0, state = RUN.
  - ifIdPc = 0, ifIdInstr = 0, ifIdValid = 0.
  - Counters = 0.
- `instAddr` = PC, combinational from the PC register.
- Branch target = ifIdPc + 4 + (brOffset << 2), modulo 2^WORD_LEN.
  - Bits [1:0] of the target are always 00.
- Per-cycle priority: `rst` > `brTaken` > `freeze` > state action.
- `brTaken` (either state):
  - PC ← target, state ← RUN.
  - IF/ID flushed: instr 0, valid 0, pc 0.
  - Overrides a simultaneous `freeze`.
- `freeze` without `brTaken`: PC, state and IF/ID all hold.
- RUN, no freeze/branch:
  - IF/ID ← {PC, `instruction`}, valid 1.
  - PC ← PC + 4.
  - If PC + 4 ≥ PROG_BYTES, state ← DONE.
- DONE, no branch:
  - PC holds.
  - IF/ID ← NOP (instr 0, valid 0, pc 0).
  - A later `brTaken` from an in-flight branch re-enters RUN.
- PC increment wraps modulo 2^WORD_LEN. The memory truncates high address bits; no error is flagged.
- Reset asserted mid-operation (including during freeze or a branch) wins on that edge; no partial update.

## Timing
- Memory read is combinational: IF/ID captures the word addressed by the current PC on the same edge that advances the PC.
- A branch resolved in ID in cycle N:
  - Target PC is loaded at edge N.
  - The target instruction appears in IF/ID after edge N+1.
  - Exactly one bubble (the flushed wrong-path fetch).
- `freeze` takes effect at the same edge it is sampled, with no added latency. An N-cycle freeze delays the stream by exactly N cycles.
- DONE is entered on the edge that fetches the last word. `ifIdValid` falls one cycle later.

## Configuration
- Macro: `IF_PERF_CNT_EN`.
- Defined:
  - Adds `fetchCount` and `stallCount`, both reset to 0.
  - `fetchCount` increments on every edge that loads IF/ID with valid = 1.
  - `stallCount` increments on every edge with `freeze`=1 and `brTaken`=0 in RUN.
  - Both counters wrap at 2^32.
- Undefined: both ports and their counter logic are absent; all other behaviour is identical.

## Test plan
- Reset then 3 free-running cycles, memory words A,B,C at 0,4,8:
  - `instAddr` shows 0, 4, 8, 12.
  - IF/ID shows (0,A), (4,B), (8,C), all valid.
- Reset held while `freeze`=1 and `brTaken`=1:
  - PC = 0 and IF/ID = (0,0,valid 0) after each edge.
- Branch in ID with ifIdPc=32, brOffset=-3, `brTaken`=1:
  - PC becomes 24 and IF/ID is flushed to valid 0.
  - Next edge: IF/ID = (24, word@24).
- `freeze`=1 for 2 cycles at PC=12:
  - PC stays 12 and IF/ID is unchanged for both cycles.
  - Release: IF/ID = (12, word@12).
  - With the macro: stallCount = 2.
- `freeze`=1 and `brTaken`=1 together, ifIdPc=40, brOffset=-8:
  - PC = 12 and IF/ID is flushed; freeze is ignored.
- Run a 44-byte program to the end (PROG_BYTES=44):
  - After fetching 40, state is DONE and PC holds 44.
  - ifIdValid = 0 from the following cycle.
  - A later `brTaken` with ifIdPc=40, offset -8 resumes at PC 12.
  - With the macro: fetchCount = 11 at DONE entry.
